// File: rtl/secded_pkg.sv
// +----------------------------------------------------------------------------+
// | secded_pkg                                                                 |
// | Shared SECDED helpers: code geometry, data-position map, error kinds.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package secded_pkg;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SINGLE = 2'd1,
    ERR_DOUBLE = 2'd2,
    ERR_PARITY = 2'd3
  } err_e;

  // Smallest r with 2**r >= data_w + r + 1.
  function automatic int calc_par_w(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < data_w + r + 1) r++;
    return r;
  endfunction

  function automatic int calc_n(input int data_w);
    return data_w + calc_par_w(data_w);
  endfunction

  // 1-based Hamming position of payload bit idx (skips power-of-two check slots).
  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = -1;
    while (cnt < idx) begin
      pos++;
      if ((pos & (pos - 1)) != 0) cnt++;
    end
    return pos;
  endfunction

endpackage

`default_nettype wire

// File: rtl/secded_syndrome.sv
// +----------------------------------------------------------------------------+
// | secded_syndrome                                                            |
// | Combinational Hamming syndrome and overall parity of a received word.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module secded_syndrome #(
  parameter int N     = 7,
  parameter int PAR_W = 3
) (
  input  logic [N-1:0]     i_code,
  input  logic             i_parity,
  output logic [PAR_W-1:0] o_syndrome,
  output logic             o_parity_odd
);

  // Syndrome bit j covers every position whose 1-based index has bit j set.
  always_comb begin
    o_syndrome = '0;
    for (int j = 0; j < PAR_W; j++) begin
      for (int k = 0; k < N; k++) begin
        if ((((k + 1) >> j) & 1) == 1) o_syndrome[j] = o_syndrome[j] ^ i_code[k];
      end
    end
    o_parity_odd = ^{i_parity, i_code};
  end

endmodule

`default_nettype wire

// File: rtl/secded_decoder_pipe.sv
// +----------------------------------------------------------------------------+
// | secded_decoder_pipe                                                        |
// | Two-stage SECDED decoder with valid/ready flow and saturating counters.    |
// | Option: SECDED_ERR_INJECT_EN adds i_inj_mask fault-injection port.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module secded_decoder_pipe
  import secded_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int N      = calc_n(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [N-1:0]      i_code,
  input  logic              i_parity,
`ifdef SECDED_ERR_INJECT_EN
  input  logic [N:0]        i_inj_mask,
`endif
  input  logic              i_cnt_clr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [PAR_W-1:0]  o_syndrome,
  output logic              o_1bit_error,
  output logic              o_2bit_error,
  output logic              o_parity_error,
  output logic [CNT_W-1:0]  o_cnt_1bit,
  output logic [CNT_W-1:0]  o_cnt_2bit
);

  logic              adv;
  logic              hs;
  logic [N-1:0]      code_in;
  logic              par_in;
  logic [PAR_W-1:0]  syn_in;
  logic              odd_in;

  logic              s1_valid_q, s1_valid_d;
  logic [N-1:0]      s1_code_q,  s1_code_d;
  logic [PAR_W-1:0]  s1_syn_q,   s1_syn_d;
  logic              s1_odd_q,   s1_odd_d;

  err_e              err;
  logic [N-1:0]      fixed;
  logic [DATA_W-1:0] dec_data;

  logic              o_valid_q, o_valid_d;
  logic [DATA_W-1:0] o_data_q,  o_data_d;
  logic [PAR_W-1:0]  o_syn_q,   o_syn_d;
  logic              o_1bit_q,  o_1bit_d;
  logic              o_2bit_q,  o_2bit_d;
  logic              o_par_q,   o_par_d;
  logic [CNT_W-1:0]  cnt1_q,    cnt1_d;
  logic [CNT_W-1:0]  cnt2_q,    cnt2_d;

  assign adv     = ~o_valid_q | i_ready;
  assign hs      = o_valid_q & i_ready;
  assign o_ready = adv;

`ifdef SECDED_ERR_INJECT_EN
  assign code_in = i_code ^ i_inj_mask[N-1:0];
  assign par_in  = i_parity ^ i_inj_mask[N];
`else
  assign code_in = i_code;
  assign par_in  = i_parity;
`endif

  secded_syndrome #(
    .N     (N),
    .PAR_W (PAR_W)
  ) u_syndrome (
    .i_code       (code_in),
    .i_parity     (par_in),
    .o_syndrome   (syn_in),
    .o_parity_odd (odd_in)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_odd_d   = s1_odd_q;
    if (adv) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_code_d = code_in;
        s1_syn_d  = syn_in;
        s1_odd_d  = odd_in;
      end
    end
  end

  // Syndromes beyond the codeword length cannot name a real bit: uncorrectable.
  always_comb begin
    err = ERR_NONE;
    if (int'(s1_syn_q) > N)      err = ERR_DOUBLE;
    else if (s1_syn_q != '0)     err = s1_odd_q ? ERR_SINGLE : ERR_DOUBLE;
    else if (s1_odd_q)           err = ERR_PARITY;
    fixed = s1_code_q;
    if (err == ERR_SINGLE) begin
      for (int k = 0; k < N; k++) begin
        if (int'(s1_syn_q) == k + 1) fixed[k] = ~fixed[k];
      end
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_data
    localparam int P = data_pos(i) - 1;
    assign dec_data[i] = fixed[P];
  end

  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_syn_d   = o_syn_q;
    o_1bit_d  = o_1bit_q;
    o_2bit_d  = o_2bit_q;
    o_par_d   = o_par_q;
    if (adv) begin
      o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        o_data_d = dec_data;
        o_syn_d  = s1_syn_q;
        o_1bit_d = (err == ERR_SINGLE);
        o_2bit_d = (err == ERR_DOUBLE);
        o_par_d  = (err == ERR_PARITY);
      end
    end
  end

  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (i_cnt_clr) begin
      cnt1_d = '0;
      cnt2_d = '0;
    end else if (hs) begin
      if (o_1bit_q && !(&cnt1_q)) cnt1_d = cnt1_q + 1'b1;
      if (o_2bit_q && !(&cnt2_q)) cnt2_d = cnt2_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_odd_q   <= 1'b0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_syn_q    <= '0;
      o_1bit_q   <= 1'b0;
      o_2bit_q   <= 1'b0;
      o_par_q    <= 1'b0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_code_q  <= s1_code_d;
      s1_syn_q   <= s1_syn_d;
      s1_odd_q   <= s1_odd_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_syn_q    <= o_syn_d;
      o_1bit_q   <= o_1bit_d;
      o_2bit_q   <= o_2bit_d;
      o_par_q    <= o_par_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
    end
  end

  assign o_valid        = o_valid_q;
  assign o_data         = o_data_q;
  assign o_syndrome     = o_syn_q;
  assign o_1bit_error   = o_1bit_q;
  assign o_2bit_error   = o_2bit_q;
  assign o_parity_error = o_par_q;
  assign o_cnt_1bit     = cnt1_q;
  assign o_cnt_2bit     = cnt2_q;

endmodule

`default_nettype wire
